// File: rtl/latch_bank_sched.sv
// Write sequencer and arbiter for a bank of keep/load latch registers.
// Grants one requester at a time and drives a setup/load/hold sequence, or a bulk clear.
module latch_bank_sched #(
  parameter int NREGS      = 8,
  parameter int AW         = 3,
  parameter int DW         = 8,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clk,
  input  logic             res,
  input  logic             a_req,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_data,
  output logic             a_ack,
  input  logic             b_req,
  input  logic [AW-1:0]    b_addr,
  input  logic [DW-1:0]    b_data,
  output logic             b_ack,
  input  logic             clr_req,
  output logic             clr_ack,
  output logic [DW-1:0]    bank_d,
  output logic [NREGS-1:0] bank_en,
  output logic             bank_phi_keep,
  output logic             bank_res2,
  output logic             busy,
  output logic             last_grant
);

  localparam int CW = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, HOLD, CLR} state_t;

  state_t            state;
  logic [CW-1:0]     clr_cnt;
  logic              served_b;
  logic              grant_b;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_data;
  logic [NREGS-1:0]  sel_en;

  // Round-robin pick; an address outside the bank decodes to no enable at all.
  always_comb begin
    grant_b  = b_req && (!a_req || !last_grant);
    sel_addr = grant_b ? b_addr : a_addr;
    sel_data = grant_b ? b_data : a_data;
    sel_en   = '0;
    for (int i = 0; i < NREGS; i++) begin
      sel_en[i] = (sel_addr == AW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      served_b      <= 1'b0;
      bank_d        <= '0;
      bank_en       <= '0;
      bank_phi_keep <= 1'b1;
      bank_res2     <= 1'b0;
      a_ack         <= 1'b0;
      b_ack         <= 1'b0;
      clr_ack       <= 1'b0;
      busy          <= 1'b0;
      last_grant    <= 1'b1;
    end else begin
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      clr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state         <= CLR;
            clr_cnt       <= CW'(CLR_CYCLES);
            bank_res2     <= 1'b1;
            bank_en       <= '0;
            bank_phi_keep <= 1'b1;
            busy          <= 1'b1;
            clr_ack       <= (CLR_CYCLES == 1);
          end else if (a_req || b_req) begin
            state         <= SETUP;
            bank_d        <= sel_data;
            bank_en       <= sel_en;
            bank_phi_keep <= 1'b1;
            last_grant    <= grant_b;
            served_b      <= grant_b;
            busy          <= 1'b1;
          end
        end
        SETUP: begin
          state         <= LOAD;
          bank_phi_keep <= 1'b0;
        end
        LOAD: begin
          state         <= HOLD;
          bank_phi_keep <= 1'b1;
          a_ack         <= !served_b;
          b_ack         <= served_b;
        end
        HOLD: begin
          state   <= IDLE;
          bank_en <= '0;
          busy    <= 1'b0;
        end
        CLR: begin
          // clr_cnt counts the CLR cycles still to run, including the current one.
          if (clr_cnt == CW'(1)) begin
            state     <= IDLE;
            bank_res2 <= 1'b0;
            busy      <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt - CW'(1);
            clr_ack <= (clr_cnt == CW'(2));
          end
        end
        default: begin
          state         <= IDLE;
          bank_en       <= '0;
          bank_phi_keep <= 1'b1;
          bank_res2     <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_bank_sched.sv
// Bench for latch_bank_sched: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_latch_bank_sched;

  localparam int NREGS      = 6;
  localparam int AW         = 3;
  localparam int DW         = 8;
  localparam int CLR_CYCLES = 2;

  logic             clk = 1'b0;
  logic             res;
  logic             a_req, b_req, clr_req;
  logic [AW-1:0]    a_addr, b_addr;
  logic [DW-1:0]    a_data, b_data;
  logic             a_ack, b_ack, clr_ack;
  logic [DW-1:0]    bank_d;
  logic [NREGS-1:0] bank_en;
  logic             bank_phi_keep, bank_res2, busy, last_grant;

  int checks = 0;
  int errors = 0;

  latch_bank_sched #(.NREGS(NREGS), .AW(AW), .DW(DW), .CLR_CYCLES(CLR_CYCLES)) dut (
    .clk(clk), .res(res),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
    .clr_req(clr_req), .clr_ack(clr_ack),
    .bank_d(bank_d), .bank_en(bank_en), .bank_phi_keep(bank_phi_keep),
    .bank_res2(bank_res2), .busy(busy), .last_grant(last_grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    d;
    logic [NREGS-1:0] en;
    logic             keep, res2, aack, back, cack, busy;
  } out_t;

  out_t q[$];
  out_t cur;
  bit   m_lg = 1'b1;
  bit   model_valid = 1'b0;

  function automatic out_t mk(input logic [DW-1:0] d, input logic [NREGS-1:0] en,
                              input logic keep, input logic res2, input logic aack,
                              input logic back, input logic cack, input logic bsy);
    out_t o;
    o.d = d; o.en = en; o.keep = keep; o.res2 = res2;
    o.aack = aack; o.back = back; o.cack = cack; o.busy = bsy;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                               input logic br, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                               input logic cr);
    a_req = ar; a_addr = aa; a_data = ad;
    b_req = br; b_addr = ba; b_data = bd;
    clr_req = cr;
  endtask

  // Each accepted operation expands into its full list of per-cycle outputs,
  // ending with the mandatory idle cycle; a new decision is made only once the list drains.
  always @(posedge clk) begin
    logic             pick_b;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    dat;
    logic [NREGS-1:0] e;
    if (res) begin
      q.delete();
      m_lg = 1'b1;
      cur = mk('0, '0, 1, 0, 0, 0, 0, 0);
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (q.size() == 0) begin
        if (clr_req) begin
          for (int i = 0; i < CLR_CYCLES; i++)
            q.push_back(mk(cur.d, '0, 1, 1, 0, 0, (i == CLR_CYCLES - 1), 1));
          q.push_back(mk(cur.d, '0, 1, 0, 0, 0, 0, 0));
        end else if (a_req || b_req) begin
          pick_b = b_req && (!a_req || (m_lg == 1'b0));
          addr   = pick_b ? b_addr : a_addr;
          dat    = pick_b ? b_data : a_data;
          e      = (int'(addr) < NREGS) ? NREGS'(1 << addr) : '0;
          m_lg   = pick_b;
          q.push_back(mk(dat, e, 1, 0, 0, 0, 0, 1));
          q.push_back(mk(dat, e, 0, 0, 0, 0, 0, 1));
          q.push_back(mk(dat, e, 1, 0, !pick_b, pick_b, 0, 1));
          q.push_back(mk(dat, '0, 1, 0, 0, 0, 0, 0));
        end
      end
      if (q.size() != 0) cur = q.pop_front();
      else cur = mk(cur.d, '0, 1, 0, 0, 0, 0, 0);
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("m_bank_d", 32'(bank_d), 32'(cur.d));
      checkOutput("m_bank_en", 32'(bank_en), 32'(cur.en));
      checkOutput("m_phi_keep", 32'(bank_phi_keep), 32'(cur.keep));
      checkOutput("m_res2", 32'(bank_res2), 32'(cur.res2));
      checkOutput("m_a_ack", 32'(a_ack), 32'(cur.aack));
      checkOutput("m_b_ack", 32'(b_ack), 32'(cur.back));
      checkOutput("m_clr_ack", 32'(clr_ack), 32'(cur.cack));
      checkOutput("m_busy", 32'(busy), 32'(cur.busy));
      checkOutput("m_last_grant", 32'(last_grant), 32'(m_lg));
    end
  end

  // which: 0 = a_ack, 1 = b_ack, 2 = clr_ack; returns negedges waited, 0 on timeout
  task automatic waitAck(input int which, output int cyc);
    logic seen;
    cyc = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      seen = (which == 0) ? a_ack : (which == 1) ? b_ack : clr_ack;
      if (seen) begin
        cyc = n;
        return;
      end
    end
    checkOutput("ack_timeout", 32'(which), 32'hFFFF_FFFF);
  endtask

  task automatic doReset();
    res = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    int c;
    res = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_keep", 32'(bank_phi_keep), 32'd1);
    checkOutput("rst_en", 32'(bank_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_last_grant", 32'(last_grant), 32'd1);
    checkOutput("rst_res2", 32'(bank_res2), 32'd0);
    checkOutput("rst_d", 32'(bank_d), 32'd0);

    $display("[TB] single A write");
    res = 1'b0;
    applyStimulus(1, 5, 8'hA5, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_setup_en", 32'(bank_en), 32'b10_0000);
    checkOutput("t1_setup_keep", 32'(bank_phi_keep), 32'd1);
    checkOutput("t1_setup_d", 32'(bank_d), 32'hA5);
    @(negedge clk);
    checkOutput("t1_load_en", 32'(bank_en), 32'b10_0000);
    checkOutput("t1_load_keep", 32'(bank_phi_keep), 32'd0);
    checkOutput("t1_load_ack", 32'(a_ack), 32'd0);
    @(negedge clk);
    checkOutput("t1_hold_en", 32'(bank_en), 32'b10_0000);
    checkOutput("t1_hold_keep", 32'(bank_phi_keep), 32'd1);
    checkOutput("t1_hold_ack", 32'(a_ack), 32'd1);
    applyStimulus(0, 5, 8'hA5, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t1_idle_en", 32'(bank_en), 32'd0);
    checkOutput("t1_idle_ack", 32'(a_ack), 32'd0);
    checkOutput("t1_idle_d", 32'(bank_d), 32'hA5);
    checkOutput("t1_idle_busy", 32'(busy), 32'd0);

    $display("[TB] contention");
    doReset();
    applyStimulus(1, 1, 8'h11, 1, 2, 8'h22, 0);
    @(negedge clk);
    checkOutput("t2_first_d", 32'(bank_d), 32'h11);
    checkOutput("t2_first_grant", 32'(last_grant), 32'd0);
    waitAck(0, c);
    checkOutput("t2_a_ack_latency", 32'(c), 32'd2);
    applyStimulus(0, 1, 8'h11, 1, 2, 8'h22, 0);
    waitAck(1, c);
    checkOutput("t2_b_after_a", 32'(c), 32'd4);
    checkOutput("t2_grant_b", 32'(last_grant), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 3, 8'h33, 1, 4, 8'h44, 0);
    @(negedge clk);
    checkOutput("t2_second_grant", 32'(last_grant), 32'd0);
    checkOutput("t2_second_en", 32'(bank_en), 32'b00_1000);
    checkOutput("t2_second_d", 32'(bank_d), 32'h33);
    waitAck(0, c);
    applyStimulus(0, 3, 8'h33, 1, 4, 8'h44, 0);
    waitAck(1, c);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] clear priority");
    doReset();
    applyStimulus(1, 0, 8'h5A, 1, 1, 8'h77, 1);
    @(negedge clk);
    checkOutput("t3_c1_res2", 32'(bank_res2), 32'd1);
    checkOutput("t3_c1_keep", 32'(bank_phi_keep), 32'd1);
    checkOutput("t3_c1_ack", 32'(clr_ack), 32'd0);
    @(negedge clk);
    checkOutput("t3_c2_res2", 32'(bank_res2), 32'd1);
    checkOutput("t3_c2_keep", 32'(bank_phi_keep), 32'd1);
    checkOutput("t3_c2_ack", 32'(clr_ack), 32'd1);
    checkOutput("t3_c2_grant", 32'(last_grant), 32'd1);
    applyStimulus(1, 0, 8'h5A, 1, 1, 8'h77, 0);
    @(negedge clk);
    checkOutput("t3_idle_res2", 32'(bank_res2), 32'd0);
    checkOutput("t3_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t3_a_en", 32'(bank_en), 32'b00_0001);
    checkOutput("t3_a_d", 32'(bank_d), 32'h5A);
    waitAck(0, c);
    applyStimulus(0, 0, 8'h5A, 1, 1, 8'h77, 0);
    waitAck(1, c);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("[TB] clear during write");
    applyStimulus(1, 2, 8'hC3, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1, 2, 8'hC3, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t4_hold_ack", 32'(a_ack), 32'd1);
    checkOutput("t4_hold_res2", 32'(bank_res2), 32'd0);
    applyStimulus(0, 2, 8'hC3, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("t4_idle_res2", 32'(bank_res2), 32'd0);
    @(negedge clk);
    checkOutput("t4_clr_res2", 32'(bank_res2), 32'd1);
    checkOutput("t4_clr_d", 32'(bank_d), 32'hC3);
    waitAck(2, c);
    checkOutput("t4_clr_ack_latency", 32'(c), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("[TB] out of range");
    applyStimulus(0, 0, 0, 1, 7, 8'h3C, 0);
    @(negedge clk);
    checkOutput("t5_setup_en", 32'(bank_en), 32'd0);
    checkOutput("t5_setup_d", 32'(bank_d), 32'h3C);
    @(negedge clk);
    checkOutput("t5_load_en", 32'(bank_en), 32'd0);
    @(negedge clk);
    checkOutput("t5_hold_en", 32'(bank_en), 32'd0);
    checkOutput("t5_hold_ack", 32'(b_ack), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    applyStimulus(1, 6, 8'h66, 0, 0, 0, 0);
    waitAck(0, c);
    checkOutput("t5_a6_en", 32'(bank_en), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("[TB] reset mid-op");
    applyStimulus(1, 4, 8'h44, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_load_keep", 32'(bank_phi_keep), 32'd0);
    checkOutput("t6_load_grant", 32'(last_grant), 32'd0);
    res = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("t6_keep", 32'(bank_phi_keep), 32'd1);
    checkOutput("t6_en", 32'(bank_en), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_ack", 32'(a_ack), 32'd0);
    checkOutput("t6_grant", 32'(last_grant), 32'd1);
    res = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_no_late_ack", 32'(a_ack), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
